// File: rtl/arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter: state encoding,
// class count, credit width and the weight clamp.
package arb_pkg;

   localparam int unsigned NUM_CLASSES = 4;
   localparam int unsigned CREDIT_W    = 4;

   typedef enum logic {
      ARB_IDLE,
      ARB_SERVE
   } arb_state_e;

   // A weight of zero would starve a class, so it is clamped to one grant.
   function automatic logic [CREDIT_W-1:0] eff_weight(input int unsigned w);
      return (w == 0) ? CREDIT_W'(1) : CREDIT_W'(w);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first asserted request at or after start (mod 4).
module rr_pick
   import arb_pkg::*;
(
   input  logic [NUM_CLASSES-1:0] req,
   input  logic [1:0]             start,
   output logic                   found,
   output logic [1:0]             idx
);

   logic [1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = start;
      cand  = start;
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
         cand = start + 2'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/arbitro_wrr.sv
// Four-to-one weighted round-robin arbiter draining input FIFOs into one
// output FIFO; pop is combinational, push/sel are registered one cycle later.
module arbitro_wrr
   import arb_pkg::*;
#(
   parameter int unsigned W0 = 1,
   parameter int unsigned W1 = 1,
   parameter int unsigned W2 = 2,
   parameter int unsigned W3 = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_CLASSES-1:0] empty,
   input  logic                   almost_full,
   output logic [NUM_CLASSES-1:0] pop,
   output logic                   push,
   output logic [1:0]             sel
);

   arb_state_e            state_q, state_d;
   logic [1:0]            grant_q, grant_d;
   logic [1:0]            ptr_q, ptr_d;
   logic [CREDIT_W-1:0]   credit_q, credit_d;
   logic                  push_q;
   logic [1:0]            sel_q;

   logic                  pick_found;
   logic [1:0]            pick_idx;
   logic [CREDIT_W-1:0]   pick_wt;
   logic [NUM_CLASSES-1:0] pop_c;
   logic [1:0]            pop_idx;

   rr_pick u_pick (
      .req   (~empty),
      .start (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      case (pick_idx)
         2'd0:    pick_wt = eff_weight(W0);
         2'd1:    pick_wt = eff_weight(W1);
         2'd2:    pick_wt = eff_weight(W2);
         default: pick_wt = eff_weight(W3);
      endcase
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ptr_d    = ptr_q;
      credit_d = credit_q;
      pop_c    = '0;
      pop_idx  = grant_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_found && !almost_full) begin
               pop_c[pick_idx] = 1'b1;
               pop_idx         = pick_idx;
               grant_d         = pick_idx;
               credit_d        = pick_wt - CREDIT_W'(1);
               if (pick_wt > CREDIT_W'(1)) state_d = ARB_SERVE;
               else                        ptr_d   = pick_idx + 2'd1;
            end
         end
         ARB_SERVE: begin
            if (!almost_full) begin
               if (!empty[grant_q]) begin
                  pop_c[grant_q] = 1'b1;
                  credit_d       = credit_q - CREDIT_W'(1);
                  if (credit_q == CREDIT_W'(1)) begin
                     state_d = ARB_IDLE;
                     ptr_d   = grant_q + 2'd1;
                  end
               end else begin
                  // Early empty: one bubble, leftover credit is dropped.
                  state_d  = ARB_IDLE;
                  ptr_d    = grant_q + 2'd1;
                  credit_d = '0;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ARB_IDLE;
         grant_q  <= '0;
         ptr_q    <= '0;
         credit_q <= '0;
         push_q   <= 1'b0;
         sel_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
         push_q   <= |pop_c;
         if (|pop_c) sel_q <= pop_idx;
      end
   end

   assign pop  = reset ? pop_c : '0;
   assign push = push_q;
   assign sel  = sel_q;

endmodule

// File: tb/tb_arbitro_wrr.sv
// Directed phases plus random traffic, checked against a burst-level model of
// weighted round-robin sharing over per-FIFO word counts.
module tb_arbitro_wrr;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] empty;
   logic       almost_full;
   logic [3:0] pop;
   logic       push;
   logic [1:0] sel;

   int total = 0;
   int bad   = 0;

   arbitro_wrr #(.W0(1), .W1(1), .W2(2), .W3(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .empty       (empty),
      .almost_full (almost_full),
      .pop         (pop),
      .push        (push),
      .sel         (sel)
   );

   always #5 clk = ~clk;

   // Model: words waiting per FIFO, burst holder and grants left in its burst.
   int  weight[4] = '{1, 1, 2, 4};
   int  cnt[4];
   bit  in_burst;
   int  holder;
   int  left;
   int  start;
   int  last_pop;

   function automatic int expected_pick(input bit af);
      if (af) return -1;
      if (in_burst) return (cnt[holder] > 0) ? holder : -1;
      for (int k = 0; k < 4; k++)
         if (cnt[(start + k) % 4] > 0) return (start + k) % 4;
      return -1;
   endfunction

   function automatic void model_advance(input bit af, input int p);
      if (af) return;
      if (!in_burst) begin
         if (p >= 0) begin
            if (weight[p] > 1) begin
               in_burst = 1; holder = p; left = weight[p] - 1;
            end else start = (p + 1) % 4;
         end
      end else if (p >= 0) begin
         left--;
         if (left == 0) begin in_burst = 0; start = (holder + 1) % 4; end
      end else begin
         in_burst = 0; start = (holder + 1) % 4;
      end
      if (p >= 0) cnt[p]--;
   endfunction

   function automatic void model_reset();
      in_burst = 0; holder = 0; left = 0; start = 0; last_pop = -1;
   endfunction

   task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive_empty();
      for (int i = 0; i < 4; i++) empty[i] = (cnt[i] == 0);
   endtask

   // One cycle: drive inputs, check pop/push/sel, then cross the clock edge.
   task automatic cycle(input bit af, input int want = -2);
      int p;
      logic [3:0] exp_pop;
      almost_full = af;
      drive_empty();
      #1;
      p = expected_pick(af);
      exp_pop = (p >= 0) ? (4'b0001 << p) : 4'b0000;
      check4("pop", pop, exp_pop);
      if (want != -2) check4("pop_seq", pop, (want >= 0) ? (4'b0001 << want) : 4'b0000);
      check2("push", {1'b0, push}, {1'b0, last_pop >= 0});
      if (last_pop >= 0) check2("sel", sel, 2'(last_pop));
      @(posedge clk);
      model_advance(af, p);
      last_pop = p;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   int seq[8] = '{0, 1, 2, 2, 3, 3, 3, 3};

   initial begin
      reset = 1'b0; almost_full = 1'b0; empty = 4'b1111;
      cnt = '{0, 0, 0, 0};
      model_reset();
      #2;
      check4("rst_pop", pop, 4'b0000);
      check2("rst_push", {1'b0, push}, 2'b00);
      check2("rst_sel", sel, 2'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Idle with every FIFO empty.
      for (int c = 0; c < 10; c++) cycle(1'b0, -1);

      // Weighted sharing with all FIFOs backed up.
      cnt = '{100, 100, 100, 100};
      for (int c = 0; c < 16; c++) cycle(1'b0, seq[c % 8]);

      // Early empty on input 3: two words then a bubble, then input 0.
      do_reset();
      cnt = '{100, 100, 100, 2};
      for (int c = 0; c < 4; c++) cycle(1'b0);
      cycle(1'b0, 3);
      cycle(1'b0, 3);
      cycle(1'b0, -1);
      cycle(1'b0, 0);
      cycle(1'b0, 1);

      // Back-pressure mid-burst on input 3 with two credits left.
      do_reset();
      cnt = '{100, 100, 100, 100};
      for (int c = 0; c < 6; c++) cycle(1'b0);
      for (int c = 0; c < 5; c++) cycle(1'b1, -1);
      cycle(1'b0, 3);
      cycle(1'b0, 3);
      cycle(1'b0, 0);

      // Sparse requests on 0 and 3 only; the pointer wraps 3 -> 0.
      do_reset();
      cnt = '{100, 0, 0, 100};
      cycle(1'b0, 0);
      for (int c = 0; c < 4; c++) cycle(1'b0);

      // Random traffic and back-pressure.
      do_reset();
      cnt = '{0, 0, 0, 0};
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 4) == 0) cnt[i] += $urandom_range(1, 5);
         cycle($urandom_range(0, 3) == 0);
      end

      // Asynchronous reset while serving input 3.
      do_reset();
      cnt = '{100, 100, 100, 100};
      for (int c = 0; c < 5; c++) cycle(1'b0);
      #2;
      reset = 1'b0;
      #1;
      check4("async_pop", pop, 4'b0000);
      check2("async_push", {1'b0, push}, 2'b00);
      check2("async_sel", sel, 2'd0);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      cycle(1'b0, 0);
      for (int c = 0; c < 8; c++) cycle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
